// File: rtl/controle_if.sv
// Bus between the game controller and its surroundings (setup register,
// sequence memory, buttons, LEDs, points logic).
// master: the environment that drives buttons, level and memory data.
// slave:  the controller itself.
interface controle_if;
   logic       enter;
   logic [3:0] botoes;
   logic [1:0] nivel;
   logic [3:0] seq_valor;
   logic       setup_en;
   logic [3:0] seq_idx;
   logic [3:0] leds;
   logic [3:0] round;
   logic       points_en;
   logic       fim;
   logic       vitoria;
   logic [2:0] estado;

   modport master (
      output enter, botoes, nivel, seq_valor,
      input  setup_en, seq_idx, leds, round, points_en, fim, vitoria, estado
   );

   modport slave (
      input  enter, botoes, nivel, seq_valor,
      output setup_en, seq_idx, leds, round, points_en, fim, vitoria, estado
   );
endinterface

// File: rtl/controle.sv
// Memory-game controller: shows a growing sequence on the LEDs, then checks
// the player's button presses against it, one more element per round, up to
// 15 rounds. Losing happens on a wrong/multi-button press or on inactivity.
module controle #(
   parameter int TEMPO_LED = 50,
   parameter int TIMEOUT   = 250
) (
   input  logic      clock,
   input  logic      reset,
   controle_if.slave bus
);

   // One timer serves both the LED display and the inactivity timeout.
   localparam int TMAX = (TEMPO_LED > TIMEOUT) ? TEMPO_LED : TIMEOUT;
   localparam int TW   = $clog2(TMAX + 1);

   typedef enum logic [2:0] {
      INIT      = 3'd0,
      SETUP     = 3'd1,
      MOSTRA    = 3'd2,
      ESPERA    = 3'd3,
      PROXIMA   = 3'd4,
      RESULTADO = 3'd5
   } state_t;

   state_t        state_reg,   state_next;
   logic [3:0]    round_reg,   round_next;
   logic [3:0]    idx_reg,     idx_next;
   logic [TW-1:0] timer_reg,   timer_next;
   logic [TW-1:0] dur_reg,     dur_next;
   logic          vitoria_reg, vitoria_next;
   logic          points_reg;

   logic press;
   logic correct;

   assign press   = |bus.botoes;
   assign correct = press && (bus.botoes == bus.seq_valor);

   // Next-state and datapath update rules for every state.
   always_comb begin
      state_next   = state_reg;
      round_next   = round_reg;
      idx_next     = idx_reg;
      timer_next   = timer_reg;
      dur_next     = dur_reg;
      vitoria_next = vitoria_reg;
      case (state_reg)
         INIT: begin
            round_next   = 4'd0;
            idx_next     = 4'd0;
            timer_next   = '0;
            vitoria_next = 1'b0;
            if (bus.enter)
               state_next = SETUP;
         end
         SETUP: begin
            // Level is captured once here; later changes do not affect this game.
            dur_next   = TW'(TEMPO_LED >> bus.nivel);
            idx_next   = 4'd0;
            timer_next = '0;
            state_next = MOSTRA;
         end
         MOSTRA: begin
            if (timer_reg == dur_reg - TW'(1)) begin
               timer_next = '0;
               if (idx_reg == round_reg) begin
                  idx_next   = 4'd0;
                  state_next = ESPERA;
               end else begin
                  idx_next = idx_reg + 4'd1;
               end
            end else begin
               timer_next = timer_reg + TW'(1);
            end
         end
         ESPERA: begin
            // A press in the last allowed cycle is judged before the timeout.
            if (press) begin
               if (correct) begin
                  if (idx_reg == round_reg) begin
                     state_next = PROXIMA;
                  end else begin
                     idx_next   = idx_reg + 4'd1;
                     timer_next = '0;
                  end
               end else begin
                  vitoria_next = 1'b0;
                  state_next   = RESULTADO;
               end
            end else if (timer_reg == TW'(TIMEOUT - 1)) begin
               vitoria_next = 1'b0;
               state_next   = RESULTADO;
            end else begin
               timer_next = timer_reg + TW'(1);
            end
         end
         PROXIMA: begin
            round_next = round_reg + 4'd1;
            idx_next   = 4'd0;
            timer_next = '0;
            if (round_reg == 4'd14) begin
               vitoria_next = 1'b1;
               state_next   = RESULTADO;
            end else begin
               state_next = MOSTRA;
            end
         end
         RESULTADO: begin
            if (bus.enter) begin
               round_next   = 4'd0;
               idx_next     = 4'd0;
               timer_next   = '0;
               vitoria_next = 1'b0;
               state_next   = INIT;
            end
         end
         default: begin
            round_next   = 4'd0;
            idx_next     = 4'd0;
            timer_next   = '0;
            vitoria_next = 1'b0;
            state_next   = INIT;
         end
      endcase
   end

   // State and datapath registers; reset forces INIT with everything cleared.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_reg   <= INIT;
         round_reg   <= 4'd0;
         idx_reg     <= 4'd0;
         timer_reg   <= '0;
         dur_reg     <= '0;
         vitoria_reg <= 1'b0;
         points_reg  <= 1'b0;
      end else begin
         state_reg   <= state_next;
         round_reg   <= round_next;
         idx_reg     <= idx_next;
         timer_reg   <= timer_next;
         dur_reg     <= dur_next;
         vitoria_reg <= vitoria_next;
         // High only in the first RESULTADO cycle.
         points_reg  <= (state_next == RESULTADO) && (state_reg != RESULTADO);
      end
   end

   assign bus.setup_en  = (state_reg == SETUP);
   assign bus.leds      = (state_reg == MOSTRA) ? bus.seq_valor : 4'd0;
   assign bus.fim       = (state_reg == RESULTADO);
   assign bus.vitoria   = vitoria_reg;
   assign bus.points_en = points_reg;
   assign bus.seq_idx   = idx_reg;
   assign bus.round     = round_reg;
   assign bus.estado    = state_reg;

endmodule
